// File: rtl/seg_scan_display_if.sv
// Display-data bus between the formatting logic (master) and the scan driver (slave).
interface seg_scan_display_if #(
  parameter int NUM_DIGITS = 4
);
  // load is a one-cycle strobe with no ready/back-pressure: the slave accepts every strobe.
  logic                    load;
  logic [4*NUM_DIGITS-1:0] char_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic                    blink;
  logic [7:0]              segmentos;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    frame_start;

  modport master (
    output load, char_in, dp_in, blank_in, blink,
    input  segmentos, digit_en, frame_start
  );

  modport slave (
    input  load, char_in, dp_in, blank_in, blink,
    output segmentos, digit_en, frame_start
  );
endinterface

// File: rtl/seg_scan_display.sv
// Time-multiplexed N-digit 7-segment scan driver with frame-synchronous double buffering.
// Define SEG_SCAN_BRIGHTNESS_EN to add the 3-bit bright duty-cycle input.
module seg_scan_display #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 4096,
  parameter int BLINK_FRAMES = 64,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input logic clk,
  input logic rst,
`ifdef SEG_SCAN_BRIGHTNESS_EN
  input logic [2:0] bright,
`endif
  seg_scan_display_if.slave bus
);
  localparam int PC_W  = $clog2(PRESCALE);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BF_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int CW    = 4 * NUM_DIGITS;

  localparam logic [PC_W-1:0]       PC_LAST  = PC_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BF_W-1:0]       BF_LAST  = BF_W'(BLINK_FRAMES - 1);
  localparam logic [7:0]            SEG_OFF  = {8{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF  = {NUM_DIGITS{ACTIVE_LOW}};

  function automatic logic [6:0] decode(input logic [3:0] g);
    case (g)
      4'h0:    decode = 7'h3F;
      4'h1:    decode = 7'h06;
      4'h2:    decode = 7'h5B;
      4'h3:    decode = 7'h4F;
      4'h4:    decode = 7'h66;
      4'h5:    decode = 7'h6D;
      4'h6:    decode = 7'h7D;
      4'h7:    decode = 7'h07;
      4'h8:    decode = 7'h7F;
      4'h9:    decode = 7'h6F;
      4'hA:    decode = 7'h40;
      4'hB:    decode = 7'h79;
      4'hC:    decode = 7'h73;
      4'hD:    decode = 7'h54;
      4'hE:    decode = 7'h5C;
      default: decode = 7'h00;
    endcase
  endfunction

  logic [PC_W-1:0]       pc_q, pc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CW-1:0]         pend_char_q, pend_char_d, act_char_q, act_char_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0] pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
  logic [BF_W-1:0]       blink_cnt_q, blink_cnt_d;
  logic                  blink_off_q, blink_off_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
  logic                  frame_start_q, frame_start_d;

  logic                  pc_last, boundary, bright_ok, lit;
  logic [3:0]            glyph;
  logic [NUM_DIGITS-1:0] dig_raw;

`ifdef SEG_SCAN_BRIGHTNESS_EN
  localparam int BR_W = PC_W + 4;
  logic [BR_W-1:0] duty_lim;
  assign duty_lim  = BR_W'({1'b0, bright} + 4'd1) * BR_W'(PRESCALE);
  assign bright_ok = ({1'b0, pc_q, 3'b000} < duty_lim);
`else
  assign bright_ok = 1'b1;
`endif

  always_comb begin
    pc_last  = (pc_q == PC_LAST);
    boundary = pc_last && (idx_q == IDX_LAST);

    pc_d  = pc_last ? '0 : pc_q + PC_W'(1);
    idx_d = idx_q;
    if (pc_last) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

    pend_char_d  = bus.load ? bus.char_in  : pend_char_q;
    pend_dp_d    = bus.load ? bus.dp_in    : pend_dp_q;
    pend_blank_d = bus.load ? bus.blank_in : pend_blank_q;

    // Taking the pending next-state lets a load in the boundary cycle reach the very next frame.
    act_char_d  = boundary ? pend_char_d  : act_char_q;
    act_dp_d    = boundary ? pend_dp_d    : act_dp_q;
    act_blank_d = boundary ? pend_blank_d : act_blank_q;

    blink_cnt_d = blink_cnt_q;
    blink_off_d = blink_off_q;
    if (boundary) begin
      if (blink_cnt_q == BF_LAST) begin
        blink_cnt_d = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BF_W'(1);
      end
    end

    // pc==0 is a dark dead cycle so the previous digit's segments never ghost onto this one.
    glyph = act_char_q[{idx_q, 2'b00} +: 4];
    lit   = (pc_q != '0) && !act_blank_q[idx_q] && !(bus.blink && blink_off_q) && bright_ok;

    dig_raw = '0;
    if (lit) dig_raw[idx_q] = 1'b1;

    seg_d         = (lit ? {act_dp_q[idx_q], decode(glyph)} : 8'h00) ^ SEG_OFF;
    digit_en_d    = dig_raw ^ DIG_OFF;
    frame_start_d = (pc_q == '0) && (idx_q == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= '0;
      idx_q         <= '0;
      pend_char_q   <= '1;
      pend_dp_q     <= '0;
      pend_blank_q  <= '1;
      act_char_q    <= '1;
      act_dp_q      <= '0;
      act_blank_q   <= '1;
      blink_cnt_q   <= '0;
      blink_off_q   <= 1'b0;
      seg_q         <= SEG_OFF;
      digit_en_q    <= DIG_OFF;
      frame_start_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      idx_q         <= idx_d;
      pend_char_q   <= pend_char_d;
      pend_dp_q     <= pend_dp_d;
      pend_blank_q  <= pend_blank_d;
      act_char_q    <= act_char_d;
      act_dp_q      <= act_dp_d;
      act_blank_q   <= act_blank_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_off_q   <= blink_off_d;
      seg_q         <= seg_d;
      digit_en_q    <= digit_en_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.segmentos   = seg_q;
  assign bus.digit_en    = digit_en_q;
  assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: frame-level reference model plus directed and random scenarios.
module tb_seg_scan_display;
  localparam int N  = 4;
  localparam int P  = 4;
  localparam int BF = 2;
  localparam int FR = N * P;
  localparam int W  = N + 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_scan_display_if #(.NUM_DIGITS(N)) bus ();
`ifdef SEG_SCAN_BRIGHTNESS_EN
  logic [2:0] bright = 3'd7;
`endif

  seg_scan_display #(
    .NUM_DIGITS(N), .PRESCALE(P), .BLINK_FRAMES(BF), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef SEG_SCAN_BRIGHTNESS_EN
    .bright(bright),
`endif
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w, got_w;

  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h40, 7'h79, 7'h73, 7'h54, 7'h5C, 7'h00};
  logic [7:0] basic_seg [N] = '{8'h79, 8'hF8, 8'hA4, 8'h92};

  // Reference model: position in the scan is pure arithmetic on the cycle count since reset.
  int m_t, m_pc, m_idx, m_frame, m_bv;
  logic m_lit, m_fs;
  logic [7:0] m_seg;
  logic [N-1:0] m_den;
  logic [3:0] m_pend_ch [N];
  logic [3:0] m_act_ch [N];
  logic [N-1:0] m_pend_dp, m_act_dp, m_pend_bl, m_act_bl;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_t = 0;
      for (int k = 0; k < N; k++) begin
        m_pend_ch[k] = 4'hF;
        m_act_ch[k]  = 4'hF;
      end
      m_pend_dp = '0; m_act_dp = '0;
      m_pend_bl = '1; m_act_bl = '1;
      exp_q.push_back({1'b0, {N{1'b1}}, 8'hFF});
    end else begin
      m_pc    = m_t % P;
      m_idx   = (m_t / P) % N;
      m_frame = m_t / FR;
      m_bv    = 7;
`ifdef SEG_SCAN_BRIGHTNESS_EN
      m_bv    = int'(bright);
`endif
      m_lit = (m_pc != 0) && !m_act_bl[m_idx] && !(bus.blink && ((m_frame / BF) % 2 == 1))
              && (m_pc * 8 < (m_bv + 1) * P);
      m_seg = m_lit ? {m_act_dp[m_idx], glyph_tab[m_act_ch[m_idx]]} : 8'h00;
      m_den = '0;
      if (m_lit) m_den[m_idx] = 1'b1;
      m_fs = (m_t % FR == 0);
      exp_q.push_back({m_fs, ~m_den, ~m_seg});
      if (bus.load) begin
        for (int k = 0; k < N; k++) m_pend_ch[k] = bus.char_in[4*k +: 4];
        m_pend_dp = bus.dp_in;
        m_pend_bl = bus.blank_in;
      end
      if (m_t % FR == FR - 1) begin
        m_act_ch = m_pend_ch;
        m_act_dp = m_pend_dp;
        m_act_bl = m_pend_bl;
      end
      m_t++;
    end
  end

  task automatic goto_offset(input int off);
    do @(negedge clk); while ((m_t % FR) != off);
  endtask

  task automatic drive_load(input logic [4*N-1:0] ch, input logic [N-1:0] dp, input logic [N-1:0] bl);
    bus.char_in = ch; bus.dp_in = dp; bus.blank_in = bl; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic test_reset();
    int fs_cnt;
    rst = 1'b1;
    bus.load = 1'b0; bus.char_in = '0; bus.dp_in = '0; bus.blank_in = '0; bus.blink = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.frame_start, bus.digit_en, bus.segmentos} !== {1'b0, 4'hF, 8'hFF}) begin
      errors++;
      $display("FAIL reset_values: got %h required %h", {bus.frame_start, bus.digit_en, bus.segmentos}, {1'b0, 4'hF, 8'hFF});
    end
    rst = 1'b0;
    fs_cnt = 0;
    for (int i = 0; i < 3 * FR; i++) begin
      @(negedge clk);
      exp_w = exp_q[$]; exp_q.delete();
      got_w = {bus.frame_start, bus.digit_en, bus.segmentos};
      checks++;
      if (got_w !== exp_w) begin errors++; $display("FAIL idle_model t=%0d: got %h required %h", m_t, got_w, exp_w); end
      checks++;
      if (bus.segmentos !== 8'hFF || bus.digit_en !== 4'hF || bus.frame_start !== (i % FR == 0)) begin
        errors++;
        $display("FAIL idle cycle %0d: seg %h den %h fs %b", i, bus.segmentos, bus.digit_en, bus.frame_start);
      end
      if (bus.frame_start === 1'b1) fs_cnt++;
    end
    checks++;
    if (fs_cnt != 3) begin errors++; $display("FAIL fs_count: got %0d required 3", fs_cnt); end
  endtask

  task automatic test_basic_scan();
    logic [7:0] seg_e;
    logic [N-1:0] den_e;
    bus.blink = 1'b0;
    goto_offset(8);
    drive_load(16'h5271, 4'b0001, 4'b0000);
    goto_offset(1);
    for (int i = 0; i < FR; i++) begin
      if (i > 0) @(negedge clk);
      exp_w = exp_q[$]; exp_q.delete();
      got_w = {bus.frame_start, bus.digit_en, bus.segmentos};
      checks++;
      if (got_w !== exp_w) begin errors++; $display("FAIL scan_model t=%0d: got %h required %h", m_t, got_w, exp_w); end
      den_e = (i % P == 0) ? 4'hF : ~(4'b0001 << (i / P));
      seg_e = (i % P == 0) ? 8'hFF : basic_seg[i / P];
      checks++;
      if (bus.digit_en !== den_e || bus.segmentos !== seg_e) begin
        errors++;
        $display("FAIL scan offset %0d: den %h seg %h required den %h seg %h", i, bus.digit_en, bus.segmentos, den_e, seg_e);
      end
    end
  endtask

  task automatic test_no_tearing();
    logic [7:0] seg_e;
    goto_offset(5);
    bus.char_in = 16'hFFFF; bus.dp_in = '0; bus.blank_in = '0; bus.load = 1'b1;
    for (int j = 5; j < 2 * FR; j++) begin
      @(negedge clk);
      bus.load = 1'b0;
      exp_w = exp_q[$]; exp_q.delete();
      got_w = {bus.frame_start, bus.digit_en, bus.segmentos};
      checks++;
      if (got_w !== exp_w) begin errors++; $display("FAIL tear_model t=%0d: got %h required %h", m_t, got_w, exp_w); end
      if (j % P != 0) begin
        seg_e = (j < FR) ? basic_seg[j / P] : 8'hFF;
        checks++;
        if (bus.segmentos !== seg_e) begin errors++; $display("FAIL tearing offset %0d: seg %h required %h", j, bus.segmentos, seg_e); end
      end
    end
    goto_offset(FR - 1);
    bus.char_in = 16'h8888; bus.dp_in = '0; bus.blank_in = '0; bus.load = 1'b1;
    for (int j = FR - 1; j < 2 * FR; j++) begin
      @(negedge clk);
      bus.load = 1'b0;
      exp_w = exp_q[$]; exp_q.delete();
      got_w = {bus.frame_start, bus.digit_en, bus.segmentos};
      checks++;
      if (got_w !== exp_w) begin errors++; $display("FAIL bload_model t=%0d: got %h required %h", m_t, got_w, exp_w); end
      if (j >= FR && j % P != 0) begin
        checks++;
        if (bus.segmentos !== 8'h80) begin errors++; $display("FAIL boundary_load offset %0d: seg %h required 80", j, bus.segmentos); end
      end
    end
  endtask

  task automatic test_blanking();
    logic [N-1:0] den_e;
    goto_offset(8);
    drive_load(16'h5271, 4'b0000, 4'b0100);
    goto_offset(1);
    for (int i = 0; i < FR; i++) begin
      if (i > 0) @(negedge clk);
      exp_w = exp_q[$]; exp_q.delete();
      got_w = {bus.frame_start, bus.digit_en, bus.segmentos};
      checks++;
      if (got_w !== exp_w) begin errors++; $display("FAIL blank_model t=%0d: got %h required %h", m_t, got_w, exp_w); end
      den_e = (i % P == 0 || i / P == 2) ? 4'hF : ~(4'b0001 << (i / P));
      checks++;
      if (bus.digit_en !== den_e) begin errors++; $display("FAIL blanking offset %0d: den %h required %h", i, bus.digit_en, den_e); end
    end
  endtask

  task automatic test_blink();
    int lit_cnt [8];
    int on_cnt;
    goto_offset(8);
    drive_load(16'h3210, 4'b0000, 4'b0000);
    bus.blink = 1'b1;
    goto_offset(1);
    for (int f = 0; f < 8; f++) begin
      lit_cnt[f] = 0;
      for (int i = 0; i < FR; i++) begin
        if (f > 0 || i > 0) @(negedge clk);
        exp_w = exp_q[$]; exp_q.delete();
        got_w = {bus.frame_start, bus.digit_en, bus.segmentos};
        checks++;
        if (got_w !== exp_w) begin errors++; $display("FAIL blink_model t=%0d: got %h required %h", m_t, got_w, exp_w); end
        if (bus.digit_en !== 4'hF) lit_cnt[f]++;
      end
      checks++;
      if (lit_cnt[f] != 0 && lit_cnt[f] != FR - N) begin
        errors++; $display("FAIL blink_frame %0d: lit cycles %0d required 0 or %0d", f, lit_cnt[f], FR - N);
      end
    end
    for (int f = 0; f < 6; f++) begin
      checks++;
      if ((lit_cnt[f] == 0) == (lit_cnt[f + 2] == 0)) begin
        errors++; $display("FAIL blink_period frame %0d: lit %0d vs frame+2 lit %0d", f, lit_cnt[f], lit_cnt[f + 2]);
      end
    end
    bus.blink = 1'b0;
    for (int f = 0; f < 2; f++) begin
      on_cnt = 0;
      for (int i = 0; i < FR; i++) begin
        @(negedge clk);
        if (bus.digit_en !== 4'hF) on_cnt++;
      end
      checks++;
      if (on_cnt != FR - N) begin errors++; $display("FAIL blink_off frame %0d: lit %0d required %0d", f, on_cnt, FR - N); end
    end
  endtask

  task automatic test_async_reset();
    goto_offset(8);
    drive_load(16'h1234, 4'hF, 4'h0);
    goto_offset(1);
    drive_load(16'h8888, 4'h0, 4'h0);
    goto_offset(10);
    checks++;
    if (bus.digit_en !== 4'b1011) begin errors++; $display("FAIL pre_reset: den %h required 1011", bus.digit_en); end
    #2 rst = 1'b1;
    #1;
    exp_w = exp_q[$]; exp_q.delete();
    got_w = {bus.frame_start, bus.digit_en, bus.segmentos};
    checks++;
    if (got_w !== exp_w || got_w !== {1'b0, 4'hF, 8'hFF}) begin
      errors++; $display("FAIL async_reset: got %h required %h", got_w, {1'b0, 4'hF, 8'hFF});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2 * FR; i++) begin
      @(negedge clk);
      exp_w = exp_q[$]; exp_q.delete();
      got_w = {bus.frame_start, bus.digit_en, bus.segmentos};
      checks++;
      if (got_w !== exp_w) begin errors++; $display("FAIL rst_model t=%0d: got %h required %h", m_t, got_w, exp_w); end
      checks++;
      if (got_w !== {(i % FR == 0), 4'hF, 8'hFF}) begin
        errors++; $display("FAIL post_reset cycle %0d: got %h required %h", i, got_w, {(i % FR == 0), 4'hF, 8'hFF});
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      exp_w = exp_q[$]; exp_q.delete();
      got_w = {bus.frame_start, bus.digit_en, bus.segmentos};
      checks++;
      if (got_w !== exp_w) begin errors++; $display("FAIL random_model t=%0d: got %h required %h", m_t, got_w, exp_w); end
      checks++;
      if ($countones(~bus.digit_en) > 1) begin errors++; $display("FAIL onehot t=%0d: den %h", m_t, bus.digit_en); end
      bus.load     = ($urandom_range(0, 5) == 0);
      bus.char_in  = 16'($urandom);
      bus.dp_in    = 4'($urandom_range(0, 15));
      bus.blank_in = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) bus.blink = ~bus.blink;
`ifdef SEG_SCAN_BRIGHTNESS_EN
      bright = 3'($urandom_range(0, 7));
`endif
    end
    bus.load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_no_tearing();
    test_blanking();
    test_blink();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
Parametrised time-multiplexed 7-segment scan driver, the successor to the fixed 4-digit display driver in the vending-machine front panel. It supports N digits, a programmable refresh prescaler, and per-digit blanking and decimal points. A double-buffered frame register is updated only at frame boundaries, so the display never tears. Whole-display blink, ghost-suppression dead cycles and polarity selection are built in. It sits between the main FSM display-formatting logic and the board pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
PRESCALE, 4096, clk cycles per digit slot (>=4)
BLINK_FRAMES, 64, frames per blink half-period (>=1)
ACTIVE_LOW, 1, 1 = segment and digit outputs are active-low (common anode); 0 = active-high

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
load  in  1  single-cycle strobe: capture char_in/dp_in/blank_in into the pending buffer
char_in  in  4*NUM_DIGITS  glyph codes; digit k uses [4k+3:4k]; digit 0 is the leftmost
dp_in  in  NUM_DIGITS  decimal point per digit
blank_in  in  NUM_DIGITS  1 = digit k forced dark
blink  in  1  1 = blink the whole display
segmentos  out  8  [7]=dp, [6:0]=g..a, polarity per ACTIVE_LOW
digit_en  out  NUM_DIGITS  one-hot digit select, polarity per ACTIVE_LOW
frame_start  out  1  one-cycle pulse when the scan wraps to digit 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - pc=0, idx=0.
  - pending and active buffers: all glyphs 0xF (blank), dp=0, blank=1.
  - Blink phase = ON; blink counter = 0.
  - segmentos and digit_en = all inactive (all ones if ACTIVE_LOW).
  - frame_start = 0.
- Prescaler and scan index:
  - pc counts 0..PRESCALE-1 and wraps.
  - At pc==PRESCALE-1, idx advances next cycle: idx+1, or 0 when idx==NUM_DIGITS-1.
- Frame boundary: the cycle with pc==PRESCALE-1 and idx==NUM_DIGITS-1.
  - active <= pending at the boundary.
  - If load is high in that same cycle, active <= char_in/dp_in/blank_in directly, and pending is also updated.
  - The blink counter increments at each boundary. At BLINK_FRAMES-1 it wraps to 0 and the blink phase toggles.
- load outside the boundary updates pending only. Multiple loads within one frame: the last one wins.
- Digit k is lit in a cycle iff all of the following hold:
  - idx==k;
  - pc!=0 (dead cycle for ghost suppression);
  - active blank[k]==0;
  - NOT (blink==1 AND blink phase==OFF);
  - the brightness condition (see Optional Feature) is met.
- Segments:
  - When the current digit is lit: decode(active glyph[idx]); bit7 = active dp[idx].
  - Otherwise: all inactive.
- Glyph decode:
  - 0x0–0x9 = decimal digits.
  - 0xA='-', 0xB='E', 0xC='P', 0xD='n', 0xE='o', 0xF=blank.
  - Encodings use the standard a..g map.
- Output timing: segmentos, digit_en and frame_start are registered and lag pc/idx by 1 cycle.
  - frame_start is high for exactly one cycle: the cycle in which the outputs first show idx=0 of a new frame.
- At most one digit_en bit is active in any cycle. No glitches; all outputs come straight from flops.
- blink toggled mid-frame takes effect on the next cycle. blink=0 does not reset the phase counter.
- rst asserted mid-frame: immediate return to reset values. Any pending load is discarded.

Optional Feature:
Macro SEG_SCAN_BRIGHTNESS_EN.
- Defined:
  - Extra input port bright (3 bits).
  - Within a slot, the digit is lit only while pc*8 < (bright+1)*PRESCALE, in addition to the pc!=0 rule.
  - bright is sampled every cycle.
  - bright=7 gives full duty; bright=0 gives roughly 1/8 duty.
- Undefined: the port is absent and behaviour is identical to bright=7.

Test Plan:
- Reset/idle: NUM_DIGITS=4, PRESCALE=4, ACTIVE_LOW=1; hold rst, release, no load -> segmentos=8'hFF and digit_en=4'hF forever; frame_start pulses every 16 cycles.
- Basic scan:
  - Stimulus: load char_in=16'h5271 (digit0=1, d1=7, d2=2, d3=5), dp_in=4'b0001, blank_in=0.
  - Response: from the next frame, each slot shows a dark dead cycle, then 3 lit cycles.
  - digit_en sequence 4'b1110, 4'b1101, 4'b1011, 4'b0111.
  - Digit 0 has dp active (segmentos[7]=0).
- No tearing: issue load of 16'hFFFF mid-frame (idx=1) -> the current frame finishes showing the old values; the new blank frame starts after the next frame_start; a load exactly at the boundary cycle appears in the immediately following frame.
- Blanking: blank_in=4'b0100 with valid glyphs -> digit 2 slot keeps digit_en all inactive; the other digits are unaffected.
- Blink: BLINK_FRAMES=2, blink=1 -> display alternates 2 frames lit / 2 frames dark; blink=0 -> continuously lit.
- Async reset mid-frame: assert rst at idx=2, pc=2 with no clk edge -> outputs go inactive immediately; after release the scan restarts at idx=0 with blank buffers.
- Brightness (with SEG_SCAN_BRIGHTNESS_EN): PRESCALE=16, bright=3 -> each slot is lit only for pc 1..7 (7 cycles).
